// File: rtl/control_unit.sv
// control_unit: multi-cycle RV32I control FSM. Decodes the latched
// opcode/funct fields into ALU codes, datapath mux selects and write
// strobes, runs the single-port memory handshake for fetch/load/store,
// and traps (sticky) on instructions the ALU cannot execute.
// Ports:
//   clk, resetn (async, active-low)
//   opcode[6:0], funct3[2:0], funct7b5 : instruction register fields
//   alu_result_b0 : branch condition, mem_ready : transfer done
//   mem_valid, mem_write, adr_src      : memory request
//   ir_write, pc_write, reg_write      : write strobes
//   alu_src_a, alu_src_b, result_src, imm_src, alu_control : selects
//   trap : illegal instruction
module control_unit (
    input  logic       clk,
    input  logic       resetn,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       alu_result_b0,
    input  logic       mem_ready,
    output logic       mem_valid,
    output logic       mem_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic [2:0] imm_src,
    output logic [3:0] alu_control,
    output logic       trap
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0100;
    localparam logic [3:0] ALU_EQ   = 4'b0101;
    localparam logic [3:0] ALU_XOR  = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    localparam logic [3:0] ALU_NEQ  = 4'b1010;
    localparam logic [3:0] ALU_LTU  = 4'b1011;
    localparam logic [3:0] ALU_GTEU = 4'b1111;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD,
        S_MEMWB, S_MEMWRITE, S_EXECR, S_EXECI,
        S_BRANCH, S_JAL, S_JALR, S_JALRWB,
        S_LUI, S_AUIPC, S_ALUWB, S_TRAP
    } state_t;

    state_t     r_state;
    state_t     w_dec_next;
    logic       w_arith_ok;
    logic       w_br_ok;
    logic [3:0] w_arith_code;
    logic [3:0] w_br_code;

    // Right shifts and signed compares have no ALU code: refuse them.
    assign w_arith_ok = !((funct3 == 3'b010) || (funct3 == 3'b101) ||
                          ((funct3 == 3'b001) && funct7b5));
    assign w_br_ok    = (funct3 == 3'b000) || (funct3 == 3'b001) ||
                        (funct3 == 3'b110) || (funct3 == 3'b111);

    always_comb begin
        w_arith_code = ALU_ADD;
        case (funct3)
            3'b000: w_arith_code = (r_state == S_EXECR && funct7b5)
                                   ? ALU_SUB : ALU_ADD;
            3'b111: w_arith_code = ALU_AND;
            3'b110: w_arith_code = ALU_OR;
            3'b100: w_arith_code = ALU_XOR;
            3'b011: w_arith_code = ALU_LTU;
            3'b001: w_arith_code = ALU_SLL;
            default: w_arith_code = ALU_ADD;
        endcase
    end

    always_comb begin
        w_br_code = ALU_ADD;
        case (funct3)
            3'b000: w_br_code = ALU_EQ;
            3'b001: w_br_code = ALU_NEQ;
            3'b110: w_br_code = ALU_LTU;
            3'b111: w_br_code = ALU_GTEU;
            default: w_br_code = ALU_ADD;
        endcase
    end

    always_comb begin
        w_dec_next = S_TRAP;
        case (opcode)
            OP_LOAD, OP_STORE: w_dec_next = S_MEMADR;
            OP_R:     w_dec_next = w_arith_ok ? S_EXECR : S_TRAP;
            OP_I:     w_dec_next = w_arith_ok ? S_EXECI : S_TRAP;
            OP_BR:    w_dec_next = w_br_ok ? S_BRANCH : S_TRAP;
            OP_JAL:   w_dec_next = S_JAL;
            OP_JALR:  w_dec_next = S_JALR;
            OP_LUI:   w_dec_next = S_LUI;
            OP_AUIPC: w_dec_next = S_AUIPC;
            default:  w_dec_next = S_TRAP;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_FETCH;
        end else begin
            case (r_state)
                S_FETCH:    if (mem_ready) r_state <= S_DECODE;
                S_DECODE:   r_state <= w_dec_next;
                S_MEMADR:   r_state <= (opcode == OP_STORE)
                                       ? S_MEMWRITE : S_MEMREAD;
                S_MEMREAD:  if (mem_ready) r_state <= S_MEMWB;
                S_MEMWRITE: if (mem_ready) r_state <= S_FETCH;
                S_EXECR,
                S_EXECI,
                S_JAL,
                S_LUI,
                S_AUIPC:    r_state <= S_ALUWB;
                S_JALR:     r_state <= S_JALRWB;
                S_MEMWB,
                S_BRANCH,
                S_JALRWB,
                S_ALUWB:    r_state <= S_FETCH;
                S_TRAP:     r_state <= S_TRAP;
                default:    r_state <= S_TRAP;
            endcase
        end
    end

    // Outputs are decoded from state; reset forces them all low so an
    // in-flight transfer is abandoned without waiting for a clock edge.
    always_comb begin
        mem_valid   = 1'b0;
        mem_write   = 1'b0;
        adr_src     = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        reg_write   = 1'b0;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        result_src  = 2'b00;
        imm_src     = 3'b000;
        alu_control = ALU_ADD;
        trap        = 1'b0;
        if (resetn) begin
            case (r_state)
                S_FETCH: begin
                    mem_valid  = 1'b1;
                    alu_src_b  = 2'b10;
                    result_src = 2'b10;
                    ir_write   = mem_ready;
                    pc_write   = mem_ready;
                end
                S_DECODE: begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b01;
                    imm_src   = (opcode == OP_JAL) ? IMM_J : IMM_B;
                end
                S_MEMADR: begin
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b01;
                    imm_src   = (opcode == OP_STORE) ? IMM_S : IMM_I;
                end
                S_MEMREAD: begin
                    mem_valid = 1'b1;
                    adr_src   = 1'b1;
                end
                S_MEMWB: begin
                    result_src = 2'b01;
                    reg_write  = 1'b1;
                end
                S_MEMWRITE: begin
                    mem_valid = 1'b1;
                    mem_write = 1'b1;
                    adr_src   = 1'b1;
                end
                S_EXECR: begin
                    alu_src_a   = 2'b10;
                    alu_control = w_arith_code;
                end
                S_EXECI: begin
                    alu_src_a   = 2'b10;
                    alu_src_b   = 2'b01;
                    imm_src     = IMM_I;
                    alu_control = w_arith_code;
                end
                S_BRANCH: begin
                    alu_src_a   = 2'b10;
                    alu_control = w_br_code;
                    pc_write    = alu_result_b0;
                end
                S_JAL: begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b10;
                    pc_write  = 1'b1;
                end
                S_JALR: begin
                    alu_src_a  = 2'b10;
                    alu_src_b  = 2'b01;
                    imm_src    = IMM_I;
                    result_src = 2'b10;
                    pc_write   = 1'b1;
                end
                S_JALRWB: begin
                    alu_src_a  = 2'b01;
                    alu_src_b  = 2'b10;
                    result_src = 2'b10;
                    reg_write  = 1'b1;
                end
                S_LUI: begin
                    alu_src_a = 2'b11;
                    alu_src_b = 2'b01;
                    imm_src   = IMM_U;
                end
                S_AUIPC: begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b01;
                    imm_src   = IMM_U;
                end
                S_ALUWB: begin
                    reg_write = 1'b1;
                end
                S_TRAP: begin
                    trap = 1'b1;
                end
                default: begin
                    trap = 1'b1;
                end
            endcase
        end
    end

endmodule
